// File: rtl/bus_control_unit.sv
// Bus control unit: owns the external bus and runs instruction prefetch and
// execution-unit data cycles. Fetched bytes are pushed into the prefetch queue.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   readyb             active-low ready; a bus cycle ends on the edge that samples it low
//   data_in            read data bus
//   address_out        20-bit bus address ({seg,4'h0} + offset)
//   bus_status         4'hF idle, 4'b1001 prefetch, 4'b1010 data read, 4'b1110 data write
//   bhe_n              active-low high-byte enable
//   data_out           write data bus
//   queue_full         queue cannot take two more bytes
//   push_queue         one-cycle push strobe with push_data/push_count
//   flush, flush_ps,
//   flush_pc           redirect the fetch stream to flush_ps:flush_pc
//   mem_req..mem_wdata EXU data request (held until mem_ack)
//   mem_ack, mem_rdata one-cycle completion strobe with read data
//   pfp, ps            current prefetch pointer and program segment
module bus_control_unit #(
  parameter logic [15:0] RESET_PS  = 16'hFFFF,
  parameter logic [15:0] RESET_PFP = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readyb,
  input  logic [15:0] data_in,
  output logic [19:0] address_out,
  output logic [3:0]  bus_status,
  output logic        bhe_n,
  output logic [15:0] data_out,
  input  logic        queue_full,
  output logic        push_queue,
  output logic [15:0] push_data,
  output logic [1:0]  push_count,
  input  logic        flush,
  input  logic [15:0] flush_ps,
  input  logic [15:0] flush_pc,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        mem_word,
  input  logic [19:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic        mem_ack,
  output logic [15:0] mem_rdata,
  output logic [15:0] pfp,
  output logic [15:0] ps
);

  localparam logic [3:0] StatIdle = 4'hF;
  localparam logic [3:0] StatPf   = 4'b1001;
  localparam logic [3:0] StatRd   = 4'b1010;
  localparam logic [3:0] StatWr   = 4'b1110;

  typedef enum logic [2:0] {StIdle, StPf, StRd, StWr, StRd2, StWr2} state_e;

  state_e      state_q;
  logic [19:0] address_q;
  logic [3:0]  status_q;
  logic        bhe_n_q;
  logic [15:0] data_out_q;
  logic        push_q;
  logic [15:0] push_data_q;
  logic [1:0]  push_count_q;
  logic        ack_q;
  logic [15:0] rdata_q;
  logic [15:0] pfp_q;
  logic [15:0] ps_q;
  // Flush seen while a bus cycle is in flight, applied when the transaction ends.
  logic        fl_pend_q;
  logic [15:0] fl_ps_q;
  logic [15:0] fl_pc_q;
  // Odd-address word access: second byte cycle owed after the idle clock.
  logic        split_q;
  logic [19:0] addr2_q;
  logic [7:0]  wd_hi_q;
  logic        we_q;
  logic        word_q;
  logic        odd_q;

  logic [19:0] pf_addr;
  logic        cycle_done;
  logic        split_first;
  logic        apply_flush;
  logic        busy;
  logic        do_flush;
  logic [15:0] eff_ps;
  logic [15:0] eff_pc;

  always_comb begin
    pf_addr     = {ps_q, 4'h0} + {4'h0, pfp_q};
    cycle_done  = (state_q != StIdle) && !readyb;
    split_first = ((state_q == StRd) || (state_q == StWr)) && word_q && odd_q;
    // The first half of a split word is not the end of the transaction.
    apply_flush = cycle_done && !split_first;
    busy        = (state_q != StIdle) || split_q;
    do_flush    = flush || fl_pend_q;
    eff_ps      = flush ? flush_ps : fl_ps_q;
    eff_pc      = flush ? flush_pc : fl_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      address_q    <= {RESET_PS, 4'h0} + {4'h0, RESET_PFP};
      status_q     <= StatIdle;
      bhe_n_q      <= 1'b1;
      data_out_q   <= 16'h0000;
      push_q       <= 1'b0;
      push_data_q  <= 16'h0000;
      push_count_q <= 2'd0;
      ack_q        <= 1'b0;
      rdata_q      <= 16'h0000;
      pfp_q        <= RESET_PFP;
      ps_q         <= RESET_PS;
      fl_pend_q    <= 1'b0;
      fl_ps_q      <= 16'h0000;
      fl_pc_q      <= 16'h0000;
      split_q      <= 1'b0;
      addr2_q      <= 20'h00000;
      wd_hi_q      <= 8'h00;
      we_q         <= 1'b0;
      word_q       <= 1'b0;
      odd_q        <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ack_q  <= 1'b0;

      if (cycle_done) begin
        state_q  <= StIdle;
        status_q <= StatIdle;
        bhe_n_q  <= 1'b1;
      end

      if (busy) begin
        if (apply_flush) begin
          if (do_flush) begin
            ps_q  <= eff_ps;
            pfp_q <= eff_pc;
          end
          fl_pend_q <= 1'b0;
        end else if (flush) begin
          fl_pend_q <= 1'b1;
          fl_ps_q   <= flush_ps;
          fl_pc_q   <= flush_pc;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (split_q) begin
            // High byte of an odd word goes on the low lane at addr+1.
            state_q    <= we_q ? StWr2 : StRd2;
            status_q   <= we_q ? StatWr : StatRd;
            address_q  <= addr2_q;
            bhe_n_q    <= 1'b1;
            data_out_q <= {wd_hi_q, wd_hi_q};
            split_q    <= 1'b0;
          end else if (flush) begin
            ps_q  <= flush_ps;
            pfp_q <= flush_pc;
          end else if (mem_req && !ack_q) begin
            state_q    <= mem_we ? StWr : StRd;
            status_q   <= mem_we ? StatWr : StatRd;
            address_q  <= mem_addr;
            bhe_n_q    <= ~(mem_word | mem_addr[0]);
            data_out_q <= (mem_word && !mem_addr[0]) ? mem_wdata
                                                     : {mem_wdata[7:0], mem_wdata[7:0]};
            we_q       <= mem_we;
            word_q     <= mem_word;
            odd_q      <= mem_addr[0];
            addr2_q    <= mem_addr + 20'd1;
            wd_hi_q    <= mem_wdata[15:8];
          end else if (!queue_full) begin
            state_q   <= StPf;
            status_q  <= StatPf;
            address_q <= pf_addr;
            bhe_n_q   <= 1'b0;
          end
        end
        StPf: begin
          // A flushed fetch still runs to the end but its data is dropped.
          if (!readyb && !do_flush) begin
            push_q <= 1'b1;
            if (pfp_q[0]) begin
              push_data_q  <= {8'h00, data_in[15:8]};
              push_count_q <= 2'd1;
              pfp_q        <= pfp_q + 16'd1;
            end else begin
              push_data_q  <= data_in;
              push_count_q <= 2'd2;
              pfp_q        <= pfp_q + 16'd2;
            end
          end
        end
        StRd, StWr: begin
          if (!readyb) begin
            if (split_first) begin
              split_q <= 1'b1;
              if (state_q == StRd) rdata_q[7:0] <= data_in[15:8];
            end else begin
              ack_q <= 1'b1;
              if (state_q == StRd) begin
                rdata_q <= word_q ? data_in
                                  : {8'h00, (odd_q ? data_in[15:8] : data_in[7:0])};
              end
            end
          end
        end
        StRd2, StWr2: begin
          if (!readyb) begin
            ack_q <= 1'b1;
            if (state_q == StRd2) rdata_q[15:8] <= data_in[7:0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign address_out = address_q;
  assign bus_status  = status_q;
  assign bhe_n       = bhe_n_q;
  assign data_out    = data_out_q;
  assign push_queue  = push_q;
  assign push_data   = push_data_q;
  assign push_count  = push_count_q;
  assign mem_ack     = ack_q;
  assign mem_rdata   = rdata_q;
  assign pfp         = pfp_q;
  assign ps          = ps_q;

endmodule

// File: tb/tb_bus_control_unit.sv
module tb_bus_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        readyb;
  logic [15:0] data_in;
  logic [19:0] address_out;
  logic [3:0]  bus_status;
  logic        bhe_n;
  logic [15:0] data_out;
  logic        queue_full;
  logic        push_queue;
  logic [15:0] push_data;
  logic [1:0]  push_count;
  logic        flush;
  logic [15:0] flush_ps;
  logic [15:0] flush_pc;
  logic        mem_req;
  logic        mem_we;
  logic        mem_word;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] pfp;
  logic [15:0] ps;

  bus_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .readyb     (readyb),
    .data_in    (data_in),
    .address_out(address_out),
    .bus_status (bus_status),
    .bhe_n      (bhe_n),
    .data_out   (data_out),
    .queue_full (queue_full),
    .push_queue (push_queue),
    .push_data  (push_data),
    .push_count (push_count),
    .flush      (flush),
    .flush_ps   (flush_ps),
    .flush_pc   (flush_pc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_word   (mem_word),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .pfp        (pfp),
    .ps         (ps)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Scoreboards: expectations queued when stimulus is driven, popped on strobes.
  typedef struct {logic [15:0] data; logic [1:0] cnt;} push_t;
  typedef struct {logic chk_data; logic [15:0] data;} ack_t;
  push_t push_exp[$];
  ack_t  ack_exp[$];
  push_t pe;
  ack_t  ae;

  always @(negedge clk) begin
    if (push_queue) begin
      if (push_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: push_data=%h push_count=%0d, expected no push",
                 push_data, push_count);
      end else begin
        pe = push_exp.pop_front();
        chk("push_data", 32'(push_data), 32'(pe.data));
        chk("push_count", 32'(push_count), 32'(pe.cnt));
      end
    end
    if (mem_ack) begin
      if (ack_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: mem_rdata=%h, expected no ack", mem_rdata);
      end else begin
        ae = ack_exp.pop_front();
        if (ae.chk_data) chk("mem_rdata", 32'(mem_rdata), 32'(ae.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pf_step(input logic [19:0] a, input logic [15:0] np);
    logic [15:0] d;
    chk("pf_addr", 32'(address_out), 32'(a));
    chk("pf_status", 32'(bus_status), 32'(4'b1001));
    chk("pf_bhe_n", 32'(bhe_n), 32'(1'b0));
    d = 16'($urandom);
    data_in = d;
    readyb = 1'b0;
    if (a[0]) push_exp.push_back('{{8'h00, d[15:8]}, 2'd1});
    else push_exp.push_back('{d, 2'd2});
    tick();
    chk("pf_end_status", 32'(bus_status), 32'(4'hF));
    chk("pf_next_pfp", 32'(pfp), 32'(np));
  endtask

  typedef struct {
    logic        we;
    logic        word;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] din1;
    logic [15:0] din2;
    logic        two;
    logic [19:0] a1;
    logic        b1;
    logic [15:0] d1;
    logic [15:0] m1;
    logic [19:0] a2;
    logic        b2;
    logic [15:0] d2;
    logic [15:0] m2;
    logic [15:0] rdata;
  } vec_t;

  localparam int NV = 9;
  vec_t vec[NV];
  vec_t v;

  initial begin
    // we word addr     wdata    din1     din2     two a1       b1 d1       m1
    //                                                 a2       b2 d2       m2       rdata
    vec[0] = '{1'b0, 1'b1, 20'h00101, 16'h0000, 16'hAB00, 16'h00CD, 1'b1, 20'h00101, 1'b0,
               16'h0000, 16'h0000, 20'h00102, 1'b1, 16'h0000, 16'h0000, 16'hCDAB};
    vec[1] = '{1'b0, 1'b1, 20'h00200, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 20'h00200, 1'b0,
               16'h0000, 16'h0000, 20'h00000, 1'b0, 16'h0000, 16'h0000, 16'hBEEF};
    vec[2] = '{1'b0, 1'b0, 20'h00300, 16'h0000, 16'h1234, 16'h0000, 1'b0, 20'h00300, 1'b1,
               16'h0000, 16'h0000, 20'h00000, 1'b0, 16'h0000, 16'h0000, 16'h0034};
    vec[3] = '{1'b0, 1'b0, 20'h00301, 16'h0000, 16'h1234, 16'h0000, 1'b0, 20'h00301, 1'b0,
               16'h0000, 16'h0000, 20'h00000, 1'b0, 16'h0000, 16'h0000, 16'h0012};
    vec[4] = '{1'b1, 1'b0, 20'h00400, 16'h00A5, 16'h0000, 16'h0000, 1'b0, 20'h00400, 1'b1,
               16'hA5A5, 16'hFFFF, 20'h00000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vec[5] = '{1'b1, 1'b0, 20'h00401, 16'h005A, 16'h0000, 16'h0000, 1'b0, 20'h00401, 1'b0,
               16'h5A5A, 16'hFFFF, 20'h00000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vec[6] = '{1'b1, 1'b1, 20'h00500, 16'h1357, 16'h0000, 16'h0000, 1'b0, 20'h00500, 1'b0,
               16'h1357, 16'hFFFF, 20'h00000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vec[7] = '{1'b1, 1'b1, 20'h00601, 16'h2468, 16'h0000, 16'h0000, 1'b1, 20'h00601, 1'b0,
               16'h6800, 16'hFF00, 20'h00602, 1'b1, 16'h0024, 16'h00FF, 16'h0000};
    vec[8] = '{1'b0, 1'b1, 20'hFFFFF, 16'h0000, 16'h1100, 16'h0022, 1'b1, 20'hFFFFF, 1'b0,
               16'h0000, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'h0000, 16'h2211};

    reset = 1'b1; readyb = 1'b0; data_in = 16'h0000; queue_full = 1'b0;
    flush = 1'b0; flush_ps = 16'h0000; flush_pc = 16'h0000;
    mem_req = 1'b0; mem_we = 1'b0; mem_word = 1'b0; mem_addr = 20'h0; mem_wdata = 16'h0;
    tick();
    tick();
    chk("rst_status", 32'(bus_status), 32'(4'hF));
    chk("rst_addr", 32'(address_out), 32'(20'hFFFF0));
    chk("rst_bhe_n", 32'(bhe_n), 32'(1'b1));
    chk("rst_push", 32'(push_queue), 32'(1'b0));
    chk("rst_ack", 32'(mem_ack), 32'(1'b0));
    chk("rst_data_out", 32'(data_out), 32'(16'h0000));
    chk("rst_push_data", 32'(push_data), 32'(16'h0000));
    chk("rst_push_count", 32'(push_count), 32'(2'd0));
    chk("rst_rdata", 32'(mem_rdata), 32'(16'h0000));
    chk("rst_pfp", 32'(pfp), 32'(16'h0000));
    chk("rst_ps", 32'(ps), 32'(16'hFFFF));

    // Free-running prefetch from reset: pfp 0, 2, 4.
    reset = 1'b0;
    tick();
    pf_step(20'hFFFF0, 16'h0002);
    tick();
    pf_step(20'hFFFF2, 16'h0004);
    queue_full = 1'b1;
    tick();
    chk("qfull_idle", 32'(bus_status), 32'(4'hF));

    // Redirect to an odd pointer: 1-byte fetch, then word fetches.
    flush = 1'b1; flush_ps = 16'h1000; flush_pc = 16'h0003;
    tick();
    chk("flush_ps", 32'(ps), 32'(16'h1000));
    chk("flush_pfp", 32'(pfp), 32'(16'h0003));
    chk("flush_idle", 32'(bus_status), 32'(4'hF));
    flush = 1'b0; queue_full = 1'b0;
    tick();
    pf_step(20'h10003, 16'h0004);
    tick();
    pf_step(20'h10004, 16'h0006);

    // Wait states: outputs held, single push after readyb falls.
    readyb = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", 32'(address_out), 32'(20'h10006));
      chk("wait_status", 32'(bus_status), 32'(4'b1001));
      chk("wait_no_push", 32'(push_queue), 32'(1'b0));
    end
    pf_step(20'h10006, 16'h0008);

    // Flush during a prefetch: data dropped, next fetch at the new address.
    readyb = 1'b1;
    tick();
    chk("fl_pf_addr", 32'(address_out), 32'(20'h10008));
    flush = 1'b1; flush_ps = 16'h2000; flush_pc = 16'h0010;
    tick();
    flush = 1'b0; readyb = 1'b0; queue_full = 1'b1; data_in = 16'h7777;
    tick();
    chk("fl_pf_end_status", 32'(bus_status), 32'(4'hF));
    chk("fl_pf_ps", 32'(ps), 32'(16'h2000));
    chk("fl_pf_pfp", 32'(pfp), 32'(16'h0010));
    queue_full = 1'b0;
    tick();
    pf_step(20'h20010, 16'h0012);
    queue_full = 1'b1;
    tick();

    // Data accesses from the vector table.
    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      mem_req = 1'b1; mem_we = v.we; mem_word = v.word; mem_addr = v.addr;
      mem_wdata = v.wdata; readyb = 1'b0;
      tick();
      chk("d1_addr", 32'(address_out), 32'(v.a1));
      chk("d1_bhe_n", 32'(bhe_n), 32'(v.b1));
      chk("d1_status", 32'(bus_status), 32'(v.we ? 4'b1110 : 4'b1010));
      if (v.m1 != 16'h0000) chk("d1_data_out", 32'(data_out & v.m1), 32'(v.d1));
      data_in = v.din1;
      if (!v.two) ack_exp.push_back('{!v.we, v.rdata});
      tick();
      if (v.two) begin
        chk("split_gap_status", 32'(bus_status), 32'(4'hF));
        chk("split_gap_no_ack", 32'(mem_ack), 32'(1'b0));
        tick();
        chk("d2_addr", 32'(address_out), 32'(v.a2));
        chk("d2_bhe_n", 32'(bhe_n), 32'(v.b2));
        chk("d2_status", 32'(bus_status), 32'(v.we ? 4'b1110 : 4'b1010));
        if (v.m2 != 16'h0000) chk("d2_data_out", 32'(data_out & v.m2), 32'(v.d2));
        data_in = v.din2;
        ack_exp.push_back('{!v.we, v.rdata});
        tick();
      end
      // mem_req still high in the ack cycle must not start a new access.
      tick();
      chk("req_in_ack_ignored", 32'(bus_status), 32'(4'hF));
      mem_req = 1'b0;
    end

    // Flush and mem_req together: flush first; flush during RD applies after ack.
    mem_req = 1'b1; mem_we = 1'b0; mem_word = 1'b0; mem_addr = 20'h00700;
    flush = 1'b1; flush_ps = 16'h4000; flush_pc = 16'h0100;
    tick();
    chk("flreq_idle", 32'(bus_status), 32'(4'hF));
    chk("flreq_ps", 32'(ps), 32'(16'h4000));
    chk("flreq_pfp", 32'(pfp), 32'(16'h0100));
    flush = 1'b0; readyb = 1'b1;
    tick();
    chk("flreq_rd_addr", 32'(address_out), 32'(20'h00700));
    chk("flreq_rd_status", 32'(bus_status), 32'(4'b1010));
    flush = 1'b1; flush_ps = 16'h3000; flush_pc = 16'h0020;
    tick();
    chk("flrd_ps_held", 32'(ps), 32'(16'h4000));
    flush = 1'b0; readyb = 1'b0; data_in = 16'h5566;
    ack_exp.push_back('{1'b1, 16'h0066});
    tick();
    chk("flrd_ps", 32'(ps), 32'(16'h3000));
    chk("flrd_pfp", 32'(pfp), 32'(16'h0020));
    mem_req = 1'b0;
    tick();

    // Pointer wrap inside segment 0, then reset during a wait state.
    flush = 1'b1; flush_ps = 16'h0000; flush_pc = 16'hFFFE;
    tick();
    flush = 1'b0; queue_full = 1'b0;
    tick();
    pf_step(20'h0FFFE, 16'h0000);
    readyb = 1'b1;
    tick();
    chk("wrap_addr", 32'(address_out), 32'(20'h00000));
    tick();
    reset = 1'b1; data_in = 16'h9999;
    tick();
    chk("midrst_status", 32'(bus_status), 32'(4'hF));
    chk("midrst_no_push", 32'(push_queue), 32'(1'b0));
    chk("midrst_addr", 32'(address_out), 32'(20'hFFFF0));
    chk("midrst_pfp", 32'(pfp), 32'(16'h0000));
    chk("midrst_ps", 32'(ps), 32'(16'hFFFF));
    queue_full = 1'b1; readyb = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", 32'(bus_status), 32'(4'hF));

    chk("push_sb_drained", 32'(push_exp.size()), 32'(0));
    chk("ack_sb_drained", 32'(ack_exp.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
